// File: rtl/adc_emulator.sv
`default_nettype none
// =============================================================================
// adc_emulator : serial 16-bit ADC responder for adc_com loopback bring-up
// Rev 1.0
// =============================================================================
module adc_emulator #(
    parameter logic [11:0] STEP      = 12'd1,
    parameter logic [11:0] RAMP_INIT = 12'h000
) (
    input  logic        osc_clk,
    input  logic        reset,
    input  logic        adc_clk,
    input  logic        adc_conv,
    input  logic        use_ext,
    input  logic [11:0] sample_in,
    output logic        adc_data,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_abort,
    output logic [15:0] frame_count,
    output logic [11:0] last_sample
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    logic [1:0]  clk_sync;
    logic        clk_hist;
    logic [1:0]  conv_sync;
    logic        conv_hist;
    logic        clk_rise;
    logic        clk_fall;
    logic        conv_rise;
    logic        conv_fall;

    state_t      state;
    logic [14:0] shreg;
    logic [4:0]  rise_cnt;
    logic        armed;
    logic [11:0] ramp;

    logic [11:0] sample_sel;
    logic [15:0] frame_word;

    assign sample_sel = use_ext ? sample_in : ramp;
    assign frame_word = {2'b00, sample_sel, 2'b00};

    // Synchronizers reset to 0, so a conv held low across reset release never
    // produces a falling edge.
    always_ff @(posedge osc_clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b00;
            clk_hist  <= 1'b0;
            conv_sync <= 2'b00;
            conv_hist <= 1'b0;
            clk_rise  <= 1'b0;
            clk_fall  <= 1'b0;
            conv_rise <= 1'b0;
            conv_fall <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], adc_clk};
            clk_hist  <= clk_sync[1];
            conv_sync <= {conv_sync[0], adc_conv};
            conv_hist <= conv_sync[1];
            clk_rise  <=  clk_sync[1]  & ~clk_hist;
            clk_fall  <= ~clk_sync[1]  &  clk_hist;
            conv_rise <=  conv_sync[1] & ~conv_hist;
            conv_fall <= ~conv_sync[1] &  conv_hist;
        end
    end

    always_ff @(posedge osc_clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shreg       <= 15'd0;
            rise_cnt    <= 5'd0;
            armed       <= 1'b0;
            ramp        <= RAMP_INIT;
            adc_data    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            frame_count <= 16'd0;
            last_sample <= 12'd0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    adc_data <= 1'b0;
                    // A fall seen in DONE implies a missed rise: start afresh.
                    if (conv_fall) begin
                        shreg       <= frame_word[14:0];
                        adc_data    <= frame_word[15];
                        last_sample <= sample_sel;
                        rise_cnt    <= 5'd0;
                        armed       <= 1'b0;
                        busy        <= 1'b1;
                        state       <= SHIFT;
                    end else if (conv_rise) begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (clk_rise && (rise_cnt == 5'd15)) begin
                        // Completion outranks a coincident conv rise.
                        rise_cnt    <= 5'd16;
                        armed       <= 1'b0;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        ramp        <= ramp + STEP;
                        adc_data    <= 1'b0;
                        busy        <= 1'b0;
                        state       <= conv_rise ? IDLE : DONE;
                    end else if (conv_rise) begin
                        frame_abort <= 1'b1;
                        adc_data    <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (clk_rise) begin
                        rise_cnt <= rise_cnt + 5'd1;
                        armed    <= 1'b1;
                    end else if (clk_fall && armed) begin
                        adc_data <= shreg[14];
                        shreg    <= {shreg[13:0], 1'b0};
                        armed    <= 1'b0;
                    end
                end
                default: begin
                    adc_data <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
